// File: rtl/cim_mem_arbiter_if.sv
// cim_mem_arbiter_if: request/return handshakes and registered memory bundle for one cim_mem arbiter
// Requester side (index 0=BUS_FSM, 1=LOGIC_FSM, 2=MAC):
//   req_valid/req_write/req_addr/req_wdata -> arbiter, req_ready <- arbiter (one-hot or zero)
//   rd_valid (registered source tag) and rd_data (read return) <- arbiter
// Memory side (MemAccessSignals bundle):
//   mem_read_req_src/mem_write_req_src (one-hot source), mem_addr_table, mem_write_data -> cim_mem
//   mem_rd_data <- cim_mem
interface cim_mem_arbiter_if #(
  parameter int ADDR_W    = 16,
  parameter int N_STORAGE = 16
);
  logic [2:0]                 req_valid;
  logic [2:0]                 req_write;
  logic [2:0][ADDR_W-1:0]     req_addr;
  logic [2:0][N_STORAGE-1:0]  req_wdata;
  logic [2:0]                 req_ready;
  logic [2:0]                 rd_valid;
  logic [N_STORAGE-1:0]       rd_data;
  logic [2:0]                 mem_read_req_src;
  logic [2:0]                 mem_write_req_src;
  logic [2:0][ADDR_W-1:0]     mem_addr_table;
  logic [2:0][N_STORAGE-1:0]  mem_write_data;
  logic [N_STORAGE-1:0]       mem_rd_data;
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rd_data,
    output req_ready, rd_valid, rd_data,
           mem_read_req_src, mem_write_req_src, mem_addr_table, mem_write_data
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rd_data,
    input  req_ready, rd_valid, rd_data,
           mem_read_req_src, mem_write_req_src, mem_addr_table, mem_write_data
  );
endinterface

// File: rtl/cim_mem_arbiter.sv
// cim_mem_arbiter: grants one of BUS_FSM/LOGIC_FSM/MAC per cycle onto a registered cim_mem access bundle
// Ports: clk, rst (sync, active-high), bus (cim_mem_arbiter_if.slave: requests, read return,
//   memory bundle), err_clr (clears the sticky flag), err_mac_write (sticky: MAC attempted a write)
module cim_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int N_STORAGE = 16,
  parameter int MAX_WAIT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  cim_mem_arbiter_if.slave bus,
  input  logic             err_clr,
  output logic             err_mac_write
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);
  logic [CW-1:0] wait_logic, wait_mac;
  logic          elev_logic, elev_mac, mac_wr;
  logic [2:0]    grant, xfer;
  function automatic logic [CW-1:0] next_wait(logic [CW-1:0] c, logic valid, logic won);
    return (!valid || won) ? '0 : (c == SAT) ? SAT : c + CW'(1);
  endfunction
  // A starved source is elevated above BUS_FSM; LOGIC_FSM beats MAC when both are starved.
  always_comb begin
    elev_logic = bus.req_valid[1] && wait_logic == SAT;
    elev_mac   = bus.req_valid[2] && wait_mac == SAT;
    grant      = elev_logic         ? 3'b010 :
                 elev_mac           ? 3'b100 :
                 bus.req_valid[0]   ? 3'b001 :
                 bus.req_valid[1]   ? 3'b010 :
                 bus.req_valid[2]   ? 3'b100 : 3'b000;
    mac_wr     = grant[2] && bus.req_write[2];
    xfer       = mac_wr ? 3'b000 : grant;
  end
  assign bus.req_ready = grant;
  assign bus.rd_data   = bus.mem_rd_data;
  // MAC writes are accepted on the handshake but never reach the memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_read_req_src  <= '0;
      bus.mem_write_req_src <= '0;
      bus.mem_addr_table    <= '0;
      bus.mem_write_data    <= '0;
      bus.rd_valid          <= '0;
      wait_logic            <= '0;
      wait_mac              <= '0;
      err_mac_write         <= 1'b0;
    end else begin
      bus.mem_read_req_src  <= xfer & ~bus.req_write;
      bus.mem_write_req_src <= xfer & bus.req_write;
      for (int i = 0; i < 3; i++) begin
        if (xfer[i]) begin
          bus.mem_addr_table[i] <= bus.req_addr[i];
          bus.mem_write_data[i] <= bus.req_wdata[i];
        end
      end
      bus.rd_valid          <= bus.mem_read_req_src;
      wait_logic            <= next_wait(wait_logic, bus.req_valid[1], grant[1]);
      wait_mac              <= next_wait(wait_mac, bus.req_valid[2], grant[2]);
      err_mac_write         <= mac_wr || (err_mac_write && !err_clr);
    end
  end
endmodule

// File: tb/tb_cim_mem_arbiter.sv
// tb_cim_mem_arbiter: directed and randomized checks of cim_mem_arbiter against a behavioural model
module tb_cim_mem_arbiter;
  localparam int AW = 16, NS = 16, MW = 8;
  logic clk = 1'b0, rst = 1'b1, err_clr = 1'b0, err_mac_write;
  always #5 clk = ~clk;
  cim_mem_arbiter_if #(.ADDR_W(AW), .N_STORAGE(NS)) bus ();
  cim_mem_arbiter #(.ADDR_W(AW), .N_STORAGE(NS), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr), .err_mac_write(err_mac_write)
  );
  logic [2:0]    v = '0, wr = '0;
  logic [AW-1:0] a [3];
  logic [NS-1:0] d [3];
  assign bus.req_valid = v;
  assign bus.req_write = wr;
  assign bus.req_addr  = {a[2], a[1], a[0]};
  assign bus.req_wdata = {d[2], d[1], d[0]};
  int tests = 0, fails = 0;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [NS-1:0] init_val(int x);
    return x == 'h10 ? 16'hBEEF : NS'(x * 40503) ^ 16'h5A5A;
  endfunction
  // cim_mem stand-in: sequential memory sampling the registered bundle
  logic [NS-1:0] mem [int];
  logic [NS-1:0] mem_q = '0;
  assign bus.mem_rd_data = mem_q;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_write_req_src[i]) mem[int'(bus.mem_addr_table[2'(i)][7:0])] = bus.mem_write_data[2'(i)];
      if (bus.mem_read_req_src[i]) begin
        int k;
        k = int'(bus.mem_addr_table[2'(i)][7:0]);
        mem_q <= mem.exists(k) ? mem[k] : init_val(k);
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      check("mem_no_mac_write", 32'(bus.mem_write_req_src[2]), 32'd0);
      check("mem_src_onehot", 32'($countones({bus.mem_read_req_src, bus.mem_write_req_src}) <= 1), 32'd1);
    end
  end
  // Reference model state
  logic [NS-1:0] ref_mem [int];
  int            wl = 0, wm = 0, exp_idx = 0;
  logic [2:0]    exp_rsrc = '0, exp_wsrc = '0, exp_rv = '0, last_ready = '0;
  logic [NS-1:0] exp_rd = '0, pend_rd = '0, exp_wdata = '0;
  logic [AW-1:0] exp_addr = '0;
  logic          exp_err = 1'b0;
  function automatic int pick();
    if (v[1] && wl == MW) return 1;
    if (v[2] && wm == MW) return 2;
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction
  function automatic logic [NS-1:0] ref_rd(logic [AW-1:0] x);
    int k;
    k = int'(x[7:0]);
    return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
  endfunction
  // One cycle: check outputs at the negedge, then advance the model across the posedge.
  task automatic tick();
    int w;
    logic [2:0] oh;
    @(negedge clk);
    w = pick();
    oh = w < 0 ? 3'b000 : 3'(1 << w);
    last_ready = bus.req_ready;
    check("req_ready", 32'(bus.req_ready), 32'(oh));
    check("rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
    if (exp_rv != 0) check("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    check("read_src", 32'(bus.mem_read_req_src), 32'(exp_rsrc));
    check("write_src", 32'(bus.mem_write_req_src), 32'(exp_wsrc));
    if ((exp_rsrc | exp_wsrc) != 0) check("addr", 32'(bus.mem_addr_table[2'(exp_idx)]), 32'(exp_addr));
    if (exp_wsrc != 0) check("wdata", 32'(bus.mem_write_data[2'(exp_idx)]), 32'(exp_wdata));
    check("err_mac_write", 32'(err_mac_write), 32'(exp_err));
    @(posedge clk);
    if (rst) begin
      exp_rv = '0; exp_rsrc = '0; exp_wsrc = '0; exp_err = 1'b0; wl = 0; wm = 0;
    end else begin
      exp_rv = exp_rsrc;
      exp_rd = pend_rd;
      exp_rsrc = '0;
      exp_wsrc = '0;
      if (w >= 0 && !(w == 2 && wr[2])) begin
        exp_idx = w; exp_addr = a[w]; exp_wdata = d[w];
        if (wr[w]) begin
          exp_wsrc = oh;
          ref_mem[int'(a[w][7:0])] = d[w];
        end else begin
          exp_rsrc = oh;
          pend_rd = ref_rd(a[w]);
        end
      end
      if (w == 2 && wr[2]) exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
      wl = (!v[1] || w == 1) ? 0 : (wl < MW ? wl + 1 : MW);
      wm = (!v[2] || w == 2) ? 0 : (wm < MW ? wm + 1 : MW);
    end
    #1;
  endtask
  initial begin
    int logic_at, mac_at, n;
    for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_read_src", 32'(bus.mem_read_req_src), 32'd0);
    check("rst_write_src", 32'(bus.mem_write_req_src), 32'd0);
    check("rst_err", 32'(err_mac_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_addr%0d", i), 32'(bus.mem_addr_table[2'(i)]), 32'd0);
      check($sformatf("rst_wdata%0d", i), 32'(bus.mem_write_data[2'(i)]), 32'd0);
    end
    rst = 1'b0;
    // BUS read of 0x10 returning 0xBEEF
    v = 3'b001; wr = '0; a[0] = 16'h10;
    tick();
    check("bus_read_src", 32'(bus.mem_read_req_src), 32'd1);
    v = '0;
    tick();
    check("bus_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("bus_rd_data", 32'(bus.rd_data), 32'hBEEF);
    tick();
    check("bus_rd_valid_end", 32'(bus.rd_valid), 32'd0);
    // Starvation: BUS always valid, LOGIC elevated on cycle 9, MAC right after LOGIC drops
    v = 3'b111; a[0] = 16'h1; a[1] = 16'h2; a[2] = 16'h3;
    logic_at = 0; mac_at = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (last_ready[1] && logic_at == 0) begin logic_at = k; v[1] = 1'b0; end
      if (last_ready[2] && mac_at == 0) begin mac_at = k; v[2] = 1'b0; end
      a[0] = a[0] + 16'd1;
    end
    check("logic_grant_cycle", 32'(logic_at), 32'd9);
    check("mac_grant_cycle", 32'(mac_at), 32'd10);
    v = '0;
    repeat (2) tick();
    // LOGIC write then read of the same address
    v = 3'b010; wr = 3'b010; a[1] = 16'h05; d[1] = 16'h1234;
    tick();
    wr = '0;
    tick();
    v = '0;
    tick();
    check("wr_rd_valid", 32'(bus.rd_valid), 32'b010);
    check("wr_rd_data", 32'(bus.rd_data), 32'h1234);
    tick();
    // MAC write is swallowed and flagged
    v = 3'b100; wr = 3'b100; a[2] = 16'h07; d[2] = 16'hDEAD;
    tick();
    check("mac_wr_ready", 32'(last_ready), 32'b100);
    check("mac_wr_read_src", 32'(bus.mem_read_req_src), 32'd0);
    check("mac_wr_write_src", 32'(bus.mem_write_req_src), 32'd0);
    check("mac_err_set", 32'(err_mac_write), 32'd1);
    v = '0; wr = '0;
    tick();
    check("mac_err_hold", 32'(err_mac_write), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("mac_err_clr", 32'(err_mac_write), 32'd0);
    v = 3'b100; wr = 3'b100; err_clr = 1'b1;
    tick();
    v = '0; wr = '0; err_clr = 1'b0;
    check("mac_err_set_wins", 32'(err_mac_write), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    // Four back-to-back MAC reads
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin v = 3'b100; a[2] = AW'(k); end else v = '0;
      tick();
      if (bus.rd_valid[2]) begin
        check($sformatf("mac_burst_data%0d", n), 32'(bus.rd_data), 32'(ref_rd(AW'(n))));
        n++;
      end
    end
    check("mac_burst_len", 32'(n), 32'd4);
    // Reset right after a BUS read handshake drops the return
    v = 3'b001; a[0] = 16'h20;
    tick();
    v = '0; rst = 1'b1;
    tick();
    check("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("midrst_read_src", 32'(bus.mem_read_req_src), 32'd0);
    check("midrst_addr0", 32'(bus.mem_addr_table[0]), 32'd0);
    check("midrst_err", 32'(err_mac_write), 32'd0);
    rst = 1'b0;
    tick();
    check("midrst_no_return", 32'(bus.rd_valid), 32'd0);
    // Randomized traffic honouring hold-until-ready
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (!v[s] || last_ready[s]) begin
          if ($urandom_range(0, 2) != 0) begin
            v[s]  = 1'b1;
            wr[s] = (s == 2) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
            a[s]  = AW'($urandom_range(0, 31));
            d[s]  = NS'($urandom);
          end else v[s] = 1'b0;
        end
      end
      err_clr = ($urandom_range(0, 5) == 0);
      tick();
    end
    v = '0; err_clr = 1'b0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
